coin_bcd_accum: RTL and testbench

//  Consumes single-cycle coin pulses from the per-button debounce/pulse stages.

---
 rtl/coin_pkg.sv | 34 +++
 rtl/bcd_digit_add.sv | 27 ++
 rtl/coin_bcd_accum.sv | 188 ++++++++++++++++++
 tb/tb_coin_bcd_accum.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coin_pkg (package)
// Purpose  : Shared constants for the coin BCD accumulator: BCD digit width
//            and maximum, accumulator FSM state encoding, and a helper that
//            builds the all-9s saturation pattern.
// Revision : 1.0 - initial release
// ============================================================================
package coin_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Accumulator FSM state encoding
    localparam int         ST_W      = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ADD    = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // All-9s pattern for up to 8 BCD digits; callers cast to their width.
    function automatic logic [31:0] all_nines(input int digits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < digits) begin
                r[i*BCD_W +: BCD_W] = BCD_MAX;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_add
// Purpose  : Combinational single-digit BCD adder.
// Ports    : a[3:0], b[3:0] - BCD digit operands (0..9)
//            cin            - carry in
//            s[3:0]         - BCD sum digit
//            cout           - decimal carry out
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign cout  = (w_sum > 5'd9);
    // Subtracting 10 modulo 16 on the low nibble is the same as adding 6.
    assign s     = cout ? (w_sum[3:0] + 4'd6) : w_sum[3:0];

endmodule
`default_nettype wire

// File: rtl/coin_bcd_accum.sv
`default_nettype none
// ============================================================================
// Module   : coin_bcd_accum
// Purpose  : Running BCD total of inserted coins. Coin pulses are queued in
//            per-coin pending flags and added one at a time, one BCD digit
//            per clock, using a single shared digit adder.
// Ports    : clk            - system clock
//            rst_n          - asynchronous active-low reset
//            add_a/b/c      - 1-cycle coin pulses (values VAL_A/B/C, BCD)
//            clr            - 1-cycle pulse: zero total, abort any add
//            total[4*DIGITS-1:0] - BCD running total, digit 0 in [3:0]
//            busy           - high while an add is in flight
//            upd            - 1-cycle pulse after total is written by an add
//            ovf            - overflow indication
// Config   : COIN_SAT_EN defined   -> saturate to all 9s, ovf sticky
//            COIN_SAT_EN undefined -> wrap modulo 10^DIGITS, ovf pulses
// Revision : 1.0 - initial release
// ============================================================================
module coin_bcd_accum #(
    parameter int         DIGITS = 4,
    parameter logic [7:0] VAL_A  = 8'h01,
    parameter logic [7:0] VAL_B  = 8'h05,
    parameter logic [7:0] VAL_C  = 8'h10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  add_a,
    input  logic                  add_b,
    input  logic                  add_c,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   total,
    output logic                  busy,
    output logic                  upd,
    output logic                  ovf
);

    import coin_pkg::*;

    localparam int                  c_TW       = BCD_W * DIGITS;
    localparam int                  c_IDX_W    = $clog2(DIGITS);
    localparam logic [c_IDX_W-1:0]  c_IDX_ZERO = '0;
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(DIGITS - 1);
    localparam logic [c_TW-1:0]     c_NINES    = c_TW'(all_nines(DIGITS));

    logic [ST_W-1:0]    r_state;
    logic               r_pend_a;
    logic               r_pend_b;
    logic               r_pend_c;
    logic [7:0]         r_op;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic [c_TW-1:0]    r_work;
    logic [c_TW-1:0]    r_total;
    logic               r_upd;
    logic               r_ovf;

    logic [3:0]         w_tot_dig;
    logic [3:0]         w_op_dig;
    logic [3:0]         w_sum_dig;
    logic               w_cout;

    // Current total digit selected by the digit index. The total register
    // is not touched during ADD, so it serves directly as the left operand.
    always_comb begin
        w_tot_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_tot_dig = r_total[i*BCD_W +: BCD_W];
            end
        end
    end

    // Coin values are two BCD digits; higher operand digits are zero.
    always_comb begin
        w_op_dig = '0;
        if (r_idx == c_IDX_ZERO) begin
            w_op_dig = r_op[3:0];
        end else if (r_idx == c_IDX_ONE) begin
            w_op_dig = r_op[7:4];
        end
    end

    bcd_digit_add u_digit_add (
        .a    (w_tot_dig),
        .b    (w_op_dig),
        .cin  (r_carry),
        .s    (w_sum_dig),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pend_a <= 1'b0;
            r_pend_b <= 1'b0;
            r_pend_c <= 1'b0;
            r_op     <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_work   <= '0;
            r_total  <= '0;
            r_upd    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (clr) begin
            // clr overrides everything, including same-edge coin pulses.
            r_state  <= ST_IDLE;
            r_pend_a <= 1'b0;
            r_pend_b <= 1'b0;
            r_pend_c <= 1'b0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_total  <= '0;
            r_upd    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_upd <= 1'b0;
`ifndef COIN_SAT_EN
            r_ovf <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // Priority C > B > A; the operand is latched here so
                    // the first digit is added on the very next cycle.
                    if (r_pend_c || r_pend_b || r_pend_a) begin
                        r_state <= ST_ADD;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        if (r_pend_c) begin
                            r_pend_c <= 1'b0;
                            r_op     <= VAL_C;
                        end else if (r_pend_b) begin
                            r_pend_b <= 1'b0;
                            r_op     <= VAL_B;
                        end else begin
                            r_pend_a <= 1'b0;
                            r_op     <= VAL_A;
                        end
                    end
                end
                ST_ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == c_IDX_W'(i)) begin
                            r_work[i*BCD_W +: BCD_W] <= w_sum_dig;
                        end
                    end
                    r_carry <= w_cout;
                    if (r_idx == c_IDX_LAST) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    r_upd   <= 1'b1;
`ifdef COIN_SAT_EN
                    if (r_carry) begin
                        r_total <= c_NINES;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_total <= r_work;
                    end
`else
                    r_total <= r_work;
                    r_ovf   <= r_carry;
`endif
                end
                // Operand latch is folded into the IDLE exit, so LOAD is a
                // reserved encoding that simply recovers to IDLE.
                ST_LOAD: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            // A new pulse wins over a same-edge clear of its own flag.
            if (add_a) r_pend_a <= 1'b1;
            if (add_b) r_pend_b <= 1'b1;
            if (add_c) r_pend_c <= 1'b1;
        end
    end

    assign total = r_total;
    assign busy  = (r_state != ST_IDLE);
    assign upd   = r_upd;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_coin_bcd_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_bcd_accum
// Purpose  : Self-checking bench for coin_bcd_accum: hand-computed vector
//            table, directed corner sequences and random coin traffic, all
//            compared against a decimal-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_bcd_accum;

    localparam int         DIGITS = 4;
    localparam int         TW     = 4 * DIGITS;
    localparam int         MODV   = 10 ** DIGITS;
    localparam logic [7:0] VAL_A  = 8'h01;
    localparam logic [7:0] VAL_B  = 8'h05;
    localparam logic [7:0] VAL_C  = 8'h10;
`ifdef COIN_SAT_EN
    localparam bit         SAT    = 1'b1;
`else
    localparam bit         SAT    = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          add_a = 1'b0;
    logic          add_b = 1'b0;
    logic          add_c = 1'b0;
    logic          clr   = 1'b0;
    logic [TW-1:0] total;
    logic          busy;
    logic          upd;
    logic          ovf;

    coin_bcd_accum #(
        .DIGITS (DIGITS),
        .VAL_A  (VAL_A),
        .VAL_B  (VAL_B),
        .VAL_C  (VAL_C)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .add_a (add_a),
        .add_b (add_b),
        .add_c (add_c),
        .clr   (clr),
        .total (total),
        .busy  (busy),
        .upd   (upd),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: decimal total, pending coins, and a countdown of
    // cycles until the in-flight add lands (0 = nothing in flight).
    int m_total;
    bit m_pa, m_pb, m_pc;
    int m_cnt;
    int m_op;
    bit m_upd, m_ovf;

    typedef struct {
        bit          a, b, c, cl;
        int          n;
        logic [15:0] t;
        bit          busy;
        bit          upd;
    } vec_t;
    vec_t vecs[$];

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [TW-1:0] int2bcd(input int v);
        logic [TW-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_total = 0; m_pa = 0; m_pb = 0; m_pc = 0;
        m_cnt = 0; m_op = 0; m_upd = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit a, input bit b, input bit c, input bit cl);
        if (cl) begin
            model_reset();
        end else begin
            m_upd = 0;
            if (!SAT) m_ovf = 0;
            if (m_cnt == 0) begin
                if (m_pc) begin
                    m_pc = 0; m_op = bcd2int(VAL_C); m_cnt = DIGITS + 1;
                end else if (m_pb) begin
                    m_pb = 0; m_op = bcd2int(VAL_B); m_cnt = DIGITS + 1;
                end else if (m_pa) begin
                    m_pa = 0; m_op = bcd2int(VAL_A); m_cnt = DIGITS + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_upd = 1;
                    if (m_total + m_op >= MODV) begin
                        m_ovf   = 1;
                        m_total = SAT ? MODV - 1 : m_total + m_op - MODV;
                    end else begin
                        m_total = m_total + m_op;
                    end
                end
            end
            if (a) m_pa = 1;
            if (b) m_pb = 1;
            if (c) m_pc = 1;
        end
    endtask

    task automatic check_model();
        check("model_total", total, int2bcd(m_total));
        check("model_busy",  busy,  m_cnt != 0);
        check("model_upd",   upd,   m_upd);
        check("model_ovf",   ovf,   m_ovf);
    endtask

    task automatic tick(input bit a, input bit b, input bit c, input bit cl);
        @(negedge clk);
        add_a = a; add_b = b; add_c = c; clr = cl;
        @(posedge clk);
        model_step(a, b, c, cl);
        #1;
        check_model();
    endtask

    task automatic do_add(input bit a, input bit b, input bit c);
        tick(a, b, c, 1'b0);
        repeat (DIGITS + 2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_vec(input bit a, input bit b, input bit c, input bit cl,
                           input int n, input logic [15:0] t, input bit bz, input bit up);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.cl = cl;
        v.n = n; v.t = t; v.busy = bz; v.upd = up;
        vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single add_b from zero: total lands 6 edges after the pulse edge.
        add_vec(0, 1, 0, 0, 1, 16'h0000, 0, 0);
        add_vec(0, 0, 0, 0, 5, 16'h0000, 1, 0);
        add_vec(0, 0, 0, 0, 1, 16'h0005, 0, 1);
        add_vec(0, 0, 0, 0, 1, 16'h0005, 0, 0);
        // clr, then A, B, C on one edge: processed C, B, A back to back.
        add_vec(0, 0, 0, 1, 1, 16'h0000, 0, 0);
        add_vec(1, 1, 1, 0, 1, 16'h0000, 0, 0);
        add_vec(0, 0, 0, 0, 5, 16'h0000, 1, 0);
        add_vec(0, 0, 0, 0, 1, 16'h0010, 0, 1);
        add_vec(0, 0, 0, 0, 5, 16'h0010, 1, 0);
        add_vec(0, 0, 0, 0, 1, 16'h0015, 0, 1);
        add_vec(0, 0, 0, 0, 5, 16'h0015, 1, 0);
        add_vec(0, 0, 0, 0, 1, 16'h0016, 0, 1);
        add_vec(0, 0, 0, 0, 1, 16'h0016, 0, 0);

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_total", total, 0);
        check("reset_busy",  busy,  0);
        check("reset_upd",   upd,   0);
        check("reset_ovf",   ovf,   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        foreach (vecs[k]) begin
            tick(vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].cl);
            for (int j = 1; j < vecs[k].n; j++) tick(0, 0, 0, 0);
            check($sformatf("vec%0d_total", k), total, vecs[k].t);
            check($sformatf("vec%0d_busy", k),  busy,  vecs[k].busy);
            check($sformatf("vec%0d_upd", k),   upd,   vecs[k].upd);
        end

        // Asynchronous reset in the middle of an add with pend_a queued
        tick(0, 1, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_total", total, 0);
        check("async_rst_busy",  busy,  0);
        check("async_rst_upd",   upd,   0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIGITS + 4) tick(0, 0, 0, 0);
        check("async_rst_pend_gone", busy, 0);

        // Carry chain through three digits: 0999 + 1 = 1000
        repeat (99) do_add(0, 0, 1);
        do_add(0, 1, 0);
        repeat (4) do_add(1, 0, 0);
        check("chain_pre", total, 16'h0999);
        do_add(1, 0, 0);
        check("chain_total", total, 16'h1000);
        check("chain_upd",   upd,   1);
        check("chain_ovf",   ovf,   0);

        // Overflow: 9995 + 10
        tick(0, 0, 0, 1);
        repeat (999) do_add(0, 0, 1);
        do_add(0, 1, 0);
        check("ovf_pre", total, 16'h9995);
        do_add(0, 0, 1);
`ifdef COIN_SAT_EN
        check("ovf_total", total, 16'h9999);
`else
        check("ovf_total", total, 16'h0005);
`endif
        check("ovf_flag", ovf, 1);
        check("ovf_upd",  upd, 1);
        tick(0, 0, 0, 0);
`ifdef COIN_SAT_EN
        check("ovf_sticky", ovf, 1);
`else
        check("ovf_pulse_end", ovf, 0);
`endif
        do_add(1, 0, 0);

        // clr two cycles into an add with pend_a set
        tick(0, 0, 1, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        check("clr_total", total, 0);
        check("clr_busy",  busy,  0);
        check("clr_ovf",   ovf,   0);
        repeat (DIGITS + 4) tick(0, 0, 0, 0);
        check("clr_no_upd", total, 0);
        // clr beats same-edge coin pulses
        tick(1, 1, 1, 1);
        tick(0, 0, 0, 0);
        check("clr_vs_add_busy", busy, 0);

        // Random coin traffic against the model
        for (int r = 0; r < 2000; r++) begin
            tick(($urandom_range(7) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(7) == 0), ($urandom_range(63) == 0));
        end
        tick(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
